// File: rtl/pipelined_datapath.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_datapath
// Description : Two-stage register file + ALU with valid/ready issue and
//               result handshakes, registered y/z/c and writeback bypass.
//               Optional build macro: DP_SATURATE_EN (saturating ADD/SUB).
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_datapath #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             we,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             c
);

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_shl  = 3'b101;
    localparam logic [2:0] c_op_shr  = 3'b110;
    localparam logic [2:0] c_op_pass = 3'b111;

    logic [WIDTH-1:0] r_rf [NREGS];
    logic [WIDTH-1:0] r_y;
    logic             r_z;
    logic             r_c;
    logic             r_out_valid;
    logic             r_we;
    logic [AW-1:0]    r_wa;

    logic             w_issue;
    logic             w_retire;
    logic             w_wb;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic             w_zero;

    assign in_ready = !r_out_valid || out_ready;
    assign w_issue  = in_valid && in_ready;
    assign w_retire = r_out_valid && out_ready;
    assign w_wb     = w_retire && r_we;

    // The retiring result is written at the same edge the new op samples its
    // operands, so forward it instead of the stale register contents.
    assign w_a = (w_wb && (r_wa == ra1)) ? r_y : r_rf[ra1];
    assign w_b = (w_wb && (r_wa == ra2)) ? r_y : r_rf[ra2];

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        case (opcode)
            c_op_add: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
`ifdef DP_SATURATE_EN
                if (w_sum[WIDTH]) w_res = '1;
`endif
            end
            c_op_sub: begin
                w_res = w_dif[WIDTH-1:0];
                w_cy  = w_dif[WIDTH];
`ifdef DP_SATURATE_EN
                if (w_dif[WIDTH]) w_res = '0;
`endif
            end
            c_op_and:  w_res = w_a & w_b;
            c_op_or:   w_res = w_a | w_b;
            c_op_xor:  w_res = w_a ^ w_b;
            c_op_shl: begin
                w_res = {w_a[WIDTH-2:0], 1'b0};
                w_cy  = w_a[WIDTH-1];
            end
            c_op_shr: begin
                w_res = {1'b0, w_a[WIDTH-1:1]};
                w_cy  = w_a[0];
            end
            c_op_pass: w_res = w_a;
            default:   w_res = '0;
        endcase
    end

    assign w_zero = (w_res == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
            r_y         <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_valid <= 1'b0;
            r_we        <= 1'b0;
            r_wa        <= '0;
        end else begin
            if (w_wb) r_rf[r_wa] <= r_y;
            if (w_issue) begin
                r_y         <= w_res;
                r_z         <= w_zero;
                r_c         <= w_cy;
                r_we        <= we;
                r_wa        <= wa;
                r_out_valid <= 1'b1;
            end else if (w_retire) begin
                r_out_valid <= 1'b0;
                r_we        <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign z         = r_z;
    assign c         = r_c;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_datapath
// Description : Directed self-checking bench for pipelined_datapath at
//               WIDTH=8/NREGS=4 and WIDTH=16/NREGS=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_datapath;

    localparam logic [2:0] c_add  = 3'b000;
    localparam logic [2:0] c_sub  = 3'b001;
    localparam logic [2:0] c_and  = 3'b010;
    localparam logic [2:0] c_or   = 3'b011;
    localparam logic [2:0] c_xor  = 3'b100;
    localparam logic [2:0] c_shl  = 3'b101;
    localparam logic [2:0] c_shr  = 3'b110;
    localparam logic [2:0] c_pass = 3'b111;

`ifdef DP_SATURATE_EN
    localparam logic [7:0]  c_e_add   = 8'hFF;
    localparam logic [7:0]  c_e_sub   = 8'h00;
    localparam logic        c_e_subz  = 1'b1;
    localparam logic [15:0] c_e_add16 = 16'hFFFF;
    localparam logic        c_e_z16   = 1'b0;
`else
    localparam logic [7:0]  c_e_add   = 8'h10;
    localparam logic [7:0]  c_e_sub   = 8'h30;
    localparam logic        c_e_subz  = 1'b0;
    localparam logic [15:0] c_e_add16 = 16'h0000;
    localparam logic        c_e_z16   = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv8, ir8, we8, ov8, or8, z8, c8;
    logic [1:0] ra18, ra28, wa8;
    logic [2:0] op8;
    logic [7:0] y8;

    logic        iv16, ir16, we16, ov16, or16, z16, c16;
    logic [2:0]  ra116, ra216, wa16;
    logic [2:0]  op16;
    logic [15:0] y16;

    int errors = 0;
    int checks = 0;

    pipelined_datapath #(.WIDTH(8), .NREGS(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .we(we8),
        .ra1(ra18), .ra2(ra28), .wa(wa8), .opcode(op8), .out_valid(ov8),
        .out_ready(or8), .y(y8), .z(z8), .c(c8)
    );

    pipelined_datapath #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .we(we16),
        .ra1(ra116), .ra2(ra216), .wa(wa16), .opcode(op16), .out_valid(ov16),
        .out_ready(or16), .y(y16), .z(z16), .c(c16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an op and advance to the next falling edge (issue happens at
    // the rising edge in between if in_ready is high).
    task automatic step8(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                         input logic [1:0] w, input logic wr);
        op8 = op; ra18 = a1; ra28 = a2; wa8 = w; we8 = wr; iv8 = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle8();
        iv8 = 1'b0; we8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; we8 = 1'b0; ra18 = '0; ra28 = '0; wa8 = '0; op8 = '0; or8 = 1'b1;
        iv16 = 1'b0; we16 = 1'b0; ra116 = '0; ra216 = '0; wa16 = '0; op16 = '0; or16 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_y", {24'd0, y8}, 32'd0);
        chk("rst_zc", {30'd0, z8, c8}, 32'd0);
        chk("rst_in_ready", {31'd0, ir8}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // PASS of a reset register
        chk("pass_pre_valid", {31'd0, ov8}, 32'd0);
        step8(c_pass, 2'd2, 2'd0, 2'd0, 1'b0);
        chk("pass_valid", {31'd0, ov8}, 32'd1);
        chk("pass_y", {24'd0, y8}, 32'h00);
        chk("pass_zc", {30'd0, z8, c8}, 32'b10);
        idle8();
        chk("pass_retired", {31'd0, ov8}, 32'd0);

        dut8.r_rf[1] <= 8'hF0;
        dut8.r_rf[2] <= 8'h20;
        #1;

        // ADD, then dependent PASS (bypass), then SUB, back to back
        step8(c_add, 2'd1, 2'd2, 2'd3, 1'b1);
        chk("add_y", {24'd0, y8}, {24'd0, c_e_add});
        chk("add_zc", {30'd0, z8, c8}, 32'b01);
        step8(c_pass, 2'd3, 2'd0, 2'd0, 1'b0);
        chk("bypass_y", {24'd0, y8}, {24'd0, c_e_add});
        chk("bypass_c", {31'd0, c8}, 32'd0);
        step8(c_sub, 2'd2, 2'd1, 2'd0, 1'b0);
        chk("sub_y", {24'd0, y8}, {24'd0, c_e_sub});
        chk("sub_zc", {30'd0, z8, c8}, {30'd0, c_e_subz, 1'b1});
        idle8();
        chk("add_writeback", {24'd0, dut8.r_rf[3]}, {24'd0, c_e_add});

        // Hold: consumer stalls three cycles
        or8 = 1'b0;
        step8(c_add, 2'd1, 2'd2, 2'd0, 1'b1);
        op8 = c_pass; ra18 = 2'd1; wa8 = 2'd2; we8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", {31'd0, ir8}, 32'd0);
            chk("hold_valid", {31'd0, ov8}, 32'd1);
            chk("hold_y", {24'd0, y8}, {24'd0, c_e_add});
            chk("hold_zc", {30'd0, z8, c8}, 32'b01);
            chk("hold_no_write", {24'd0, dut8.r_rf[0]}, 32'd0);
            @(negedge clk);
        end
        or8 = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, ir8}, 32'd1);
        @(negedge clk);
        chk("release_write", {24'd0, dut8.r_rf[0]}, {24'd0, c_e_add});
        chk("release_new_valid", {31'd0, ov8}, 32'd1);
        chk("release_new_y", {24'd0, y8}, 32'hF0);
        idle8();

        // Shift and logic ops
        dut8.r_rf[2] <= 8'h81;
        #1;
        step8(c_shl, 2'd2, 2'd0, 2'd0, 1'b0);
        chk("shl_y", {24'd0, y8}, 32'h02);
        chk("shl_zc", {30'd0, z8, c8}, 32'b01);
        step8(c_shr, 2'd2, 2'd0, 2'd0, 1'b0);
        chk("shr_y", {24'd0, y8}, 32'h40);
        chk("shr_c", {31'd0, c8}, 32'd1);
        step8(c_and, 2'd1, 2'd2, 2'd0, 1'b0);
        chk("and_y", {24'd0, y8}, 32'h80);
        chk("and_c", {31'd0, c8}, 32'd0);
        step8(c_or, 2'd1, 2'd2, 2'd0, 1'b0);
        chk("or_y", {24'd0, y8}, 32'hF1);
        step8(c_xor, 2'd1, 2'd1, 2'd0, 1'b0);
        chk("xor_y", {24'd0, y8}, 32'h00);
        chk("xor_zc", {30'd0, z8, c8}, 32'b10);
        idle8();

        // Reset while a writeback is pending
        or8 = 1'b0;
        step8(c_pass, 2'd1, 2'd0, 2'd3, 1'b1);
        iv8 = 1'b0;
        chk("pend_valid", {31'd0, ov8}, 32'd1);
        chk("pend_y", {24'd0, y8}, 32'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", {31'd0, ov8}, 32'd0);
        chk("areset_y", {24'd0, y8}, 32'd0);
        or8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset_rf3", {24'd0, dut8.r_rf[3]}, 32'd0);
        chk("areset_stays_idle", {31'd0, ov8}, 32'd0);

        // Wide instance: 0xFFFF + 0x0001
        dut16.r_rf[5] <= 16'hFFFF;
        dut16.r_rf[6] <= 16'h0001;
        #1;
        or16 = 1'b0;
        op16 = c_add; ra116 = 3'd5; ra216 = 3'd6; wa16 = 3'd7; we16 = 1'b1; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        chk("w16_valid", {31'd0, ov16}, 32'd1);
        chk("w16_y", {16'd0, y16}, {16'd0, c_e_add16});
        chk("w16_zc", {30'd0, z16, c16}, {30'd0, c_e_z16, 1'b1});
        @(negedge clk);
        chk("w16_hold_rf7", {16'd0, dut16.r_rf[7]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("w16_areset_valid", {31'd0, ov16}, 32'd0);
        or16 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("w16_areset_rf7", {16'd0, dut16.r_rf[7]}, 32'd0);
        chk("w16_areset_rf5", {16'd0, dut16.r_rf[5]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
